// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet source arbiter.
package pkt_pkg;

  typedef enum logic [1:0] {
    PKT_DATA = 2'd0,
    PKT_CTRL = 2'd1,
    PKT_RESP = 2'd2,
    PKT_RSVD = 2'd3
  } pkt_type_e;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int STALL_CNT_W = 8;

endpackage

// File: rtl/pkt_src_arbiter_rr_pick.sv
// Combinational cyclic first-one finder: returns the first set request at or
// after ptr, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        pick[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_src_arbiter.sv
// Round-robin packet-granular arbiter with a stall watchdog in front of the
// packet controller. Optional ctrl-type priority: PKT_ARB_CTRL_PRIO_EN.
module pkt_src_arbiter
  import pkt_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int STALL_MAX = 8,
  localparam int IW       = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   req_valid,
  input  logic [NUM_SRC-1:0]   req_eof,
  input  logic [2*NUM_SRC-1:0] req_type,
  output logic [NUM_SRC-1:0]   req_ready,
  output logic                 out_valid,
  output logic                 out_eof,
  output logic [1:0]           out_type,
  output logic [IW-1:0]        out_src_id,
  input  logic                 out_ready,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 timeout_err,
  output arb_state_e           dbg_state
);

  arb_state_e             state, state_nxt;
  logic [IW-1:0]          rr_ptr, rr_ptr_nxt;
  logic [NUM_SRC-1:0]     grant_nxt;
  logic [IW-1:0]          src_id_nxt;
  logic [STALL_CNT_W-1:0] stall_cnt, stall_nxt;
  logic                   tmo_nxt;
  logic [IW-1:0]          next_ptr;

  logic [NUM_SRC-1:0]     pick_oh;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;

`ifdef PKT_ARB_CTRL_PRIO_EN
  logic [NUM_SRC-1:0] ctrl_req, ctrl_oh, all_oh;
  logic [IW-1:0]      ctrl_idx, all_idx;
  logic               ctrl_any, all_any;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ctrl
    assign ctrl_req[gi] = req_valid[gi] && (req_type[2*gi+1 -: 2] == PKT_CTRL);
  end

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick_ctrl (
    .req (ctrl_req),
    .ptr (rr_ptr),
    .pick(ctrl_oh),
    .idx (ctrl_idx),
    .any (ctrl_any)
  );

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick_all (
    .req (req_valid),
    .ptr (rr_ptr),
    .pick(all_oh),
    .idx (all_idx),
    .any (all_any)
  );

  // Any ctrl requester wins; otherwise fall back to plain round-robin.
  assign pick_oh  = ctrl_any ? ctrl_oh  : all_oh;
  assign pick_idx = ctrl_any ? ctrl_idx : all_idx;
  assign pick_any = all_any;
`else
  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .pick(pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );
`endif

  assign next_ptr  = (out_src_id == IW'(NUM_SRC - 1)) ? '0 : out_src_id + 1'b1;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB;
      rr_ptr      <= '0;
      grant       <= '0;
      out_src_id  <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant       <= grant_nxt;
      out_src_id  <= src_id_nxt;
      stall_cnt   <= stall_nxt;
      timeout_err <= tmo_nxt;
    end
  end

  // Handshake: a beat moves when the granted source's req_valid and
  // out_ready are both high; req_ready mirrors out_ready for that source only.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    src_id_nxt = out_src_id;
    stall_nxt  = stall_cnt;
    tmo_nxt    = 1'b0;
    out_valid  = 1'b0;
    out_eof    = 1'b0;
    out_type   = 2'd0;
    req_ready  = '0;

    case (state)
      ARB: begin
        if (pick_any) begin
          grant_nxt  = pick_oh;
          src_id_nxt = pick_idx;
          stall_nxt  = '0;
          state_nxt  = LOCK;
        end
      end
      LOCK: begin
        out_valid             = req_valid[out_src_id];
        out_eof               = req_eof[out_src_id];
        out_type              = req_type[{out_src_id, 1'b0} +: 2];
        req_ready[out_src_id] = out_ready;
        if (req_valid[out_src_id]) begin
          stall_nxt = '0;
          if (out_ready && req_eof[out_src_id]) begin
            state_nxt  = ARB;
            rr_ptr_nxt = next_ptr;
            grant_nxt  = '0;
          end
        end else if (stall_cnt >= STALL_CNT_W'(STALL_MAX - 1)) begin
          // Counter is about to reach STALL_MAX: revoke the grant now.
          tmo_nxt    = 1'b1;
          stall_nxt  = '0;
          state_nxt  = ARB;
          rr_ptr_nxt = next_ptr;
          grant_nxt  = '0;
        end else if (!(&stall_cnt)) begin
          stall_nxt = stall_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

endmodule
